// File: rtl/frame_ecc_pkg.sv
// frame_ecc_pkg: record class encodings, monitor FSM
// state type and the state-transition helper.
package frame_ecc_pkg;

  localparam logic [1:0] CLS_CLEAN  = 2'b00;
  localparam logic [1:0] CLS_SINGLE = 2'b01;
  localparam logic [1:0] CLS_MULTI  = 2'b10;
  localparam logic [1:0] CLS_CRC    = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SCAN  = 2'd1;
  localparam state_t ST_ALARM = 2'd2;

  // An alarm-class event wins over a CLR in the
  // same cycle, so the new alarm is not lost.
  function automatic state_t fsm_next(
    input state_t s,
    input logic   ev,
    input logic   alarm_ev,
    input logic   clr
  );
    state_t n;
    n = s;
    if (alarm_ev) begin
      n = ST_ALARM;
    end else begin
      case (s)
        ST_IDLE:  if (ev)  n = ST_SCAN;
        ST_SCAN:  n = ST_SCAN;
        ST_ALARM: if (clr) n = ST_SCAN;
        default:  n = ST_IDLE;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/ecc_rec_fifo.sv
// ecc_rec_fifo: synchronous record FIFO, DEPTH entries.
// Ports: clk, rst (sync high), push/push_data, pop,
// pop_data (head), full, empty.
module ecc_rec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees a slot in the same cycle, so a
  // push into a full FIFO is still taken then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/frame_ecc_monitor.sv
// frame_ecc_monitor: classifies config-frame ECC/CRC
// events into a record FIFO, with counters and alarm.
// Ports: CLK, RST (sync high), ECC inputs, REC_* stream
// {class,FAR,SYNWORD,SYNBIT,SYNDROME}, CNT_*, ALARM,
// OVERFLOW, CLR (clears counters and OVERFLOW).
module frame_ecc_monitor
  import frame_ecc_pkg::*;
#(
  parameter int FAR_WIDTH  = 24,
  parameter int SYN_WIDTH  = 13,
  parameter int WORD_WIDTH = 7,
  parameter int BIT_WIDTH  = 5,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16,
  localparam int REC_W = 2 + FAR_WIDTH + WORD_WIDTH
                       + BIT_WIDTH + SYN_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CRCERROR,
  input  logic                  ECCERROR,
  input  logic                  ECCERRORSINGLE,
  input  logic                  SYNDROMEVALID,
  input  logic [FAR_WIDTH-1:0]  FAR,
  input  logic [SYN_WIDTH-1:0]  SYNDROME,
  input  logic [WORD_WIDTH-1:0] SYNWORD,
  input  logic [BIT_WIDTH-1:0]  SYNBIT,
  output logic                  REC_VALID,
  input  logic                  REC_READY,
  output logic [REC_W-1:0]      REC_DATA,
  output logic [CNT_WIDTH-1:0]  CNT_SINGLE,
  output logic [CNT_WIDTH-1:0]  CNT_MULTI,
  output logic [CNT_WIDTH-1:0]  CNT_CRC,
  output logic [CNT_WIDTH-1:0]  CNT_SCAN,
  output logic [CNT_WIDTH-1:0]  CNT_DROP,
  output logic                  ALARM,
  output logic                  OVERFLOW,
  input  logic                  CLR
);

  localparam int ZW = WORD_WIDTH + BIT_WIDTH + SYN_WIDTH;

  logic                 sv_q;
  logic                 crc_q;
  logic                 sv_edge;
  logic                 crc_edge;
  logic                 syn_rec;
  logic                 is_single;
  logic                 is_multi;
  logic [1:0]           syn_cls;
  logic                 pend_v;
  logic [FAR_WIDTH-1:0] pend_far;
  logic                 crc_direct;
  logic                 crc_to_pend;
  logic                 push_req;
  logic [REC_W-1:0]     push_data;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 drop;
  logic                 have_prev;
  logic [FAR_WIDTH-1:0] prev_far;
  logic                 wrap;
  state_t               state;

  assign sv_edge  = SYNDROMEVALID & ~sv_q;
  assign crc_edge = CRCERROR & ~crc_q;

  assign syn_rec   = sv_edge & ECCERROR;
  assign is_single = syn_rec & ECCERRORSINGLE;
  assign is_multi  = syn_rec & ~ECCERRORSINGLE;
  assign syn_cls   = ECCERRORSINGLE ? CLS_SINGLE
                                    : CLS_MULTI;

  // One push per cycle: syndrome record first, then a
  // parked CRC record, then a fresh CRC record.
  // A CRC edge that finds the slot busy only counts.
  assign crc_direct  = crc_edge & ~syn_rec & ~pend_v;
  assign crc_to_pend = crc_edge & syn_rec & ~pend_v;
  assign push_req    = syn_rec | pend_v | crc_direct;

  always_comb begin
    push_data = '0;
    if (syn_rec) begin
      push_data = {syn_cls, FAR, SYNWORD,
                   SYNBIT, SYNDROME};
    end else if (pend_v) begin
      push_data = {CLS_CRC, pend_far, {ZW{1'b0}}};
    end else if (crc_direct) begin
      push_data = {CLS_CRC, FAR, {ZW{1'b0}}};
    end
  end

  assign pop  = REC_READY & ~empty;
  assign drop = push_req & full & ~pop;

  assign wrap = sv_edge & have_prev & (FAR < prev_far);

  ecc_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push_req),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (REC_DATA),
    .full      (full),
    .empty     (empty)
  );

  assign REC_VALID = ~empty;
  assign ALARM     = (state == ST_ALARM);

  // CLR zeroes first, so an event in the CLR cycle
  // lands as a count of one.
  function automatic logic [CNT_WIDTH-1:0] bump(
    input logic [CNT_WIDTH-1:0] c,
    input logic                 clr,
    input logic                 inc
  );
    logic [CNT_WIDTH-1:0] b;
    b = clr ? '0 : c;
    if (inc && (b != '1)) b = b + CNT_WIDTH'(1);
    return b;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      sv_q      <= 1'b0;
      crc_q     <= 1'b0;
      pend_v    <= 1'b0;
      pend_far  <= '0;
      have_prev <= 1'b0;
      prev_far  <= '0;
    end else begin
      sv_q  <= SYNDROMEVALID;
      crc_q <= CRCERROR;
      if (crc_to_pend) begin
        pend_v   <= 1'b1;
        pend_far <= FAR;
      end else if (pend_v && !syn_rec) begin
        pend_v <= 1'b0;
      end
      if (sv_edge) begin
        have_prev <= 1'b1;
        prev_far  <= FAR;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      CNT_SINGLE <= '0;
      CNT_MULTI  <= '0;
      CNT_CRC    <= '0;
      CNT_SCAN   <= '0;
      CNT_DROP   <= '0;
      OVERFLOW   <= 1'b0;
    end else begin
      CNT_SINGLE <= bump(CNT_SINGLE, CLR, is_single);
      CNT_MULTI  <= bump(CNT_MULTI, CLR, is_multi);
      CNT_CRC    <= bump(CNT_CRC, CLR, crc_edge);
      CNT_SCAN   <= bump(CNT_SCAN, CLR, wrap);
      CNT_DROP   <= bump(CNT_DROP, CLR, drop);
      OVERFLOW   <= drop | (OVERFLOW & ~CLR);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= fsm_next(state,
                        sv_edge | crc_edge,
                        is_multi | crc_edge,
                        CLR);
    end
  end

endmodule

// File: tb/tb_frame_ecc_monitor.sv
// tb_frame_ecc_monitor: directed stimulus with a record
// scoreboard and direct counter/flag checks.
module tb_frame_ecc_monitor;

  localparam int FW = 24;
  localparam int SW = 13;
  localparam int WW = 7;
  localparam int BW = 5;
  localparam int CW = 16;
  localparam int RW = 2 + FW + WW + BW + SW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CRCERROR = 1'b0;
  logic          ECCERROR = 1'b0;
  logic          ECCERRORSINGLE = 1'b0;
  logic          SYNDROMEVALID = 1'b0;
  logic [FW-1:0] FAR = '0;
  logic [SW-1:0] SYNDROME = '0;
  logic [WW-1:0] SYNWORD = '0;
  logic [BW-1:0] SYNBIT = '0;
  logic          REC_VALID;
  logic          REC_READY = 1'b1;
  logic [RW-1:0] REC_DATA;
  logic [CW-1:0] CNT_SINGLE;
  logic [CW-1:0] CNT_MULTI;
  logic [CW-1:0] CNT_CRC;
  logic [CW-1:0] CNT_SCAN;
  logic [CW-1:0] CNT_DROP;
  logic          ALARM;
  logic          OVERFLOW;
  logic          CLR = 1'b0;

  always #5 CLK = ~CLK;

  frame_ecc_monitor dut (
    .CLK            (CLK),
    .RST            (RST),
    .CRCERROR       (CRCERROR),
    .ECCERROR       (ECCERROR),
    .ECCERRORSINGLE (ECCERRORSINGLE),
    .SYNDROMEVALID  (SYNDROMEVALID),
    .FAR            (FAR),
    .SYNDROME       (SYNDROME),
    .SYNWORD        (SYNWORD),
    .SYNBIT         (SYNBIT),
    .REC_VALID      (REC_VALID),
    .REC_READY      (REC_READY),
    .REC_DATA       (REC_DATA),
    .CNT_SINGLE     (CNT_SINGLE),
    .CNT_MULTI      (CNT_MULTI),
    .CNT_CRC        (CNT_CRC),
    .CNT_SCAN       (CNT_SCAN),
    .CNT_DROP       (CNT_DROP),
    .ALARM          (ALARM),
    .OVERFLOW       (OVERFLOW),
    .CLR            (CLR)
  );

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q [$];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(
    input logic [1:0]    c,
    input logic [FW-1:0] f,
    input logic [WW-1:0] w,
    input logic [BW-1:0] b,
    input logic [SW-1:0] s
  );
    return {c, f, w, b, s};
  endfunction

  // Handshake is decided by values stable between the
  // negedge and the following posedge.
  always @(negedge CLK) begin
    if (!RST && REC_VALID && REC_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rec_unexpected actual=%0h required=none",
                 REC_DATA);
      end else begin
        check("rec_data", 64'(REC_DATA), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ev_on(input logic err,
                       input logic single,
                       input logic [FW-1:0] f,
                       input logic [WW-1:0] w,
                       input logic [BW-1:0] b,
                       input logic [SW-1:0] s,
                       input logic expect_rec);
    ECCERROR       = err;
    ECCERRORSINGLE = single;
    FAR            = f;
    SYNWORD        = w;
    SYNBIT         = b;
    SYNDROME       = s;
    SYNDROMEVALID  = 1'b1;
    if (err && expect_rec)
      exp_q.push_back(mk(single ? 2'b01 : 2'b10,
                         f, w, b, s));
    tick();
  endtask

  task automatic sv_off();
    SYNDROMEVALID = 1'b0;
    tick();
  endtask

  task automatic ev(input logic err,
                    input logic single,
                    input logic [FW-1:0] f,
                    input logic expect_rec);
    ev_on(err, single, f, 7'd1, 5'd2, 13'h3, expect_rec);
    sv_off();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    REC_READY = 1'b1;
    while ((exp_q.size() != 0 || REC_VALID) && n < 50) begin
      tick();
      n++;
    end
    check({nm, "_left"}, 64'(exp_q.size()), 64'd0);
    check({nm, "_valid"}, 64'(REC_VALID), 64'd0);
  endtask

  task automatic clr_pulse();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    RST = 1'b0;
    check("rst_valid", 64'(REC_VALID), 64'd0);
    check("rst_single", 64'(CNT_SINGLE), 64'd0);
    check("rst_multi", 64'(CNT_MULTI), 64'd0);
    check("rst_crc", 64'(CNT_CRC), 64'd0);
    check("rst_drop", 64'(CNT_DROP), 64'd0);
    check("rst_alarm", 64'(ALARM), 64'd0);
    check("rst_ovf", 64'(OVERFLOW), 64'd0);

    // single event
    ev_on(1, 1, 24'h000123, 7'd5, 5'd3, 13'h0AB, 1);
    check("single_valid", 64'(REC_VALID), 64'd1);
    check("single_cnt", 64'(CNT_SINGLE), 64'd1);
    check("single_alarm", 64'(ALARM), 64'd0);
    sv_off();

    // multi event, then CLR keeps the record queued
    REC_READY = 1'b0;
    ev_on(1, 0, 24'h000200, 7'h11, 5'h1F, 13'h1555, 1);
    check("multi_cnt", 64'(CNT_MULTI), 64'd1);
    check("multi_alarm", 64'(ALARM), 64'd1);
    sv_off();
    clr_pulse();
    check("clr_alarm", 64'(ALARM), 64'd0);
    check("clr_single", 64'(CNT_SINGLE), 64'd0);
    check("clr_multi", 64'(CNT_MULTI), 64'd0);
    check("clr_valid", 64'(REC_VALID), 64'd1);
    drain("multi");

    // overflow: 10 pushes into 8 entries
    REC_READY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ev(1, 1, FW'(24'h300 + i), i < 8);
    end
    check("ovf_drop", 64'(CNT_DROP), 64'd2);
    check("ovf_flag", 64'(OVERFLOW), 64'd1);
    check("ovf_single", 64'(CNT_SINGLE), 64'd10);
    REC_READY = 1'b1;
    ev_on(1, 1, 24'h00030A, 7'd1, 5'd2, 13'h3, 1);
    check("pushpop_drop", 64'(CNT_DROP), 64'd2);
    check("pushpop_single", 64'(CNT_SINGLE), 64'd11);
    sv_off();
    drain("ovf");
    clr_pulse();
    check("clr_ovf", 64'(OVERFLOW), 64'd0);
    check("clr_drop", 64'(CNT_DROP), 64'd0);

    // CRC edge coincident with a single event
    CRCERROR = 1'b1;
    ev_on(1, 1, 24'h000400, 7'd2, 5'd4, 13'h0F0, 1);
    exp_q.push_back(mk(2'b11, 24'h000400, '0, '0, '0));
    check("coin_crc", 64'(CNT_CRC), 64'd1);
    check("coin_alarm", 64'(ALARM), 64'd1);
    CRCERROR = 1'b0;
    sv_off();
    drain("coin");
    clr_pulse();

    // scan wrap, then a 3-cycle pulse
    ev(0, 0, 24'h000010, 0);
    clr_pulse();
    ev(0, 0, 24'h000020, 0);
    ev(0, 0, 24'h000005, 0);
    check("scan_cnt", 64'(CNT_SCAN), 64'd1);
    check("scan_clean", 64'(CNT_SINGLE), 64'd0);
    ev_on(1, 1, 24'h000030, 7'd1, 5'd2, 13'h3, 1);
    tick();
    tick();
    sv_off();
    check("pulse_single", 64'(CNT_SINGLE), 64'd1);
    check("pulse_scan", 64'(CNT_SCAN), 64'd1);
    drain("pulse");

    // event in the CLR cycle counts after the clear
    CLR = 1'b1;
    ev_on(1, 0, 24'h000040, 7'd1, 5'd2, 13'h3, 1);
    CLR = 1'b0;
    check("clrev_multi", 64'(CNT_MULTI), 64'd1);
    check("clrev_single", 64'(CNT_SINGLE), 64'd0);
    check("clrev_alarm", 64'(ALARM), 64'd1);
    sv_off();
    drain("clrev");

    // reset with records queued and ALARM set
    REC_READY = 1'b0;
    ev(1, 1, 24'h000050, 1);
    ev(1, 1, 24'h000051, 1);
    ev(1, 1, 24'h000052, 1);
    check("pre_alarm", 64'(ALARM), 64'd1);
    check("pre_valid", 64'(REC_VALID), 64'd1);
    RST = 1'b1;
    tick();
    exp_q.delete();
    check("rst2_valid", 64'(REC_VALID), 64'd0);
    check("rst2_single", 64'(CNT_SINGLE), 64'd0);
    check("rst2_multi", 64'(CNT_MULTI), 64'd0);
    check("rst2_scan", 64'(CNT_SCAN), 64'd0);
    check("rst2_alarm", 64'(ALARM), 64'd0);
    RST = 1'b0;
    REC_READY = 1'b1;
    tick();
    check("post_valid", 64'(REC_VALID), 64'd0);
    ev(1, 1, 24'h000060, 1);
    check("post_alarm", 64'(ALARM), 64'd0);
    check("post_single", 64'(CNT_SINGLE), 64'd1);
    drain("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
